// File: rtl/fifo_lifo_pkg.sv
// fifo_lifo_pkg: mode and FSM types shared by the FIFO/LIFO buffer
package fifo_lifo_pkg;

    typedef enum logic {MODE_FIFO = 1'b0, MODE_LIFO = 1'b1} mode_t;

    typedef enum logic [1:0] {IDLE_FIFO, IDLE_LIFO, RUN_FIFO, RUN_LIFO} state_t;

    typedef enum logic [1:0] {Q_ZERO, Q_RAM, Q_BYP} qsrc_t;

    function automatic state_t idle_of(mode_t m);
        return m == MODE_LIFO ? IDLE_LIFO : IDLE_FIFO;
    endfunction

    function automatic state_t run_of(mode_t m);
        return m == MODE_LIFO ? RUN_LIFO : RUN_FIFO;
    endfunction

    function automatic logic is_idle(state_t s);
        return s == IDLE_FIFO || s == IDLE_LIFO;
    endfunction

endpackage

// File: rtl/fifo_lifo_sdp_ram.sv
// sdp_ram: simple dual-port storage, one write port and one registered, enabled read port
module sdp_ram #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [1 << AWIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_lifo.sv
// fifo_lifo: circular buffer popping oldest (FIFO) or newest (LIFO) word, mode latched while empty
module fifo_lifo
    import fifo_lifo_pkg::*;
#(
    parameter int DWIDTH       = 16,
    parameter int AWIDTH       = 8,
    parameter int ALMOST_FULL  = 254,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              mode_i,
    input  logic              wrreq_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              q_valid_o,
    output logic              mode_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              empty_o,
    output logic              almost_empty_o,
    output logic              full_o,
    output logic              almost_full_o
);

    localparam int DEPTH = 1 << AWIDTH;

    state_t            state, state_n;
    qsrc_t             qsrc;
    logic [AWIDTH-1:0] head, tail, head_n, tail_n, raddr;
    logic [AWIDTH:0]   cnt, cnt_n;
    logic [DWIDTH-1:0] ram_q, byp_q;
    logic              push, pop, lifo, bypass, ram_we, ram_re;

    always_comb begin
        push   = wrreq_i && !full_o;
        pop    = rdreq_i && !empty_o;
        lifo   = mode_o;
        bypass = push && pop && lifo;
        ram_we = push && !bypass;
        ram_re = pop && !bypass;
        raddr  = lifo ? head - 1'b1 : tail;
        cnt_n  = (push && !pop) ? cnt + 1'b1 : (pop && !push) ? cnt - 1'b1 : cnt;
        head_n = bypass ? head : push ? head + 1'b1 : (pop && lifo) ? head - 1'b1 : head;
        // entering IDLE re-aligns both pointers so the next mode starts from a clean buffer
        tail_n = is_idle(state_n) ? head_n : (pop && !lifo) ? tail + 1'b1 : tail;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE_FIFO;
        else          state <= state_n;
    end

    always_comb begin
        state_n = (cnt_n == '0) ? idle_of(mode_t'(mode_i)) :
                  is_idle(state) ? run_of(mode_t'(mode_i)) : state;
    end

    always_comb begin
        mode_o = (state == IDLE_LIFO) || (state == RUN_LIFO);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head           <= '0;
            tail           <= '0;
            cnt            <= '0;
            qsrc           <= Q_ZERO;
            byp_q          <= '0;
            q_valid_o      <= 1'b0;
            empty_o        <= 1'b1;
            almost_empty_o <= 1'b1;
            full_o         <= 1'b0;
            almost_full_o  <= (ALMOST_FULL == 0);
        end else begin
            head           <= head_n;
            tail           <= tail_n;
            cnt            <= cnt_n;
            q_valid_o      <= pop;
            empty_o        <= (cnt_n == '0);
            almost_empty_o <= (int'(cnt_n) <= ALMOST_EMPTY);
            full_o         <= (int'(cnt_n) == DEPTH);
            almost_full_o  <= (int'(cnt_n) >= ALMOST_FULL);
            if (pop) qsrc <= bypass ? Q_BYP : Q_RAM;
            if (bypass) byp_q <= data_i;
        end
    end

    // the RAM read register holds between pops, so q_o only needs a source select
    always_comb begin
        q_o = (qsrc == Q_RAM) ? ram_q : (qsrc == Q_BYP) ? byp_q : '0;
    end

    assign usedw_o = cnt;

    sdp_ram #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_ram (
        .clk   (clk_i),
        .we    (ram_we),
        .waddr (head),
        .wdata (data_i),
        .re    (ram_re),
        .raddr (raddr),
        .rdata (ram_q)
    );

endmodule
